// File: rtl/bus_pkg.sv
// bus_pkg: shared constants, types and helpers for bus device ports.
package bus_pkg;
  localparam logic [7:0] BROADCAST_ID = 8'hFF;
  localparam int DEFAULT_DEPTH = 8;
  typedef logic [7:0] id_t;
  typedef logic [$clog2(DEFAULT_DEPTH+1)-1:0] cnt_t;
  function automatic id_t dest_of(input logic [63:0] pkt, input int sz);
    return pkt[sz-1 -: 8];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; writes when full and reads when empty are ignored.
module sync_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [width-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [width-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);
  logic [width-1:0] mem_q [depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic wr, rd;
  assign full    = count_q == CW'(depth);
  assign empty   = count_q == '0;
  assign wr      = wr_en && !full;
  assign rd      = rd_en && !empty;
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= wr_data;
endmodule

// File: rtl/bus_device_port.sv
// bus_device_port: device end of a bus slot; TX pending FIFO popped by the bus,
// RX FIFO fed by destination-filtered pushes, with sticky error flags and a drop counter.
module bus_device_port
  import bus_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int depth = 8,
  parameter logic [7:0] id = 8'd0,
  parameter logic [7:0] broadcast = BROADCAST_ID
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_valid,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_ready,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic                       rx_valid,
  output logic [pckg_sz-1:0]         rx_data,
  input  logic                       rx_ready,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic [$clog2(depth+1)-1:0] rx_count,
  output logic                       rx_overflow,
  output logic                       rx_misroute,
  output logic                       tx_underflow,
  output logic [7:0]                 drop_cnt
);
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic match, accept, ovf, misr;
  logic rx_overflow_q, rx_misroute_q, tx_underflow_q;
  logic [7:0] drop_cnt_q;
  id_t dest;
  sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk(clk), .reset(reset), .wr_en(tx_valid), .wr_data(tx_data),
    .rd_en(pop), .rd_data(D_pop), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk(clk), .reset(reset), .wr_en(accept), .wr_data(D_push),
    .rd_en(rx_ready), .rd_data(rx_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  always_comb begin
    dest   = dest_of(64'(D_push), pckg_sz);
    match  = dest == id || dest == broadcast;
    accept = push && match;
    ovf    = accept && rx_full;
    misr   = push && !match;
  end
  assign tx_ready     = !tx_full;
  assign pndng        = !tx_empty;
  assign rx_valid     = !rx_empty;
  assign rx_overflow  = rx_overflow_q;
  assign rx_misroute  = rx_misroute_q;
  assign tx_underflow = tx_underflow_q;
  assign drop_cnt     = drop_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overflow_q  <= 1'b0;
      rx_misroute_q  <= 1'b0;
      tx_underflow_q <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      if (ovf) rx_overflow_q <= 1'b1;
      if (misr) rx_misroute_q <= 1'b1;
      if (pop && tx_empty) tx_underflow_q <= 1'b1;
      if ((ovf || misr) && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_device_port.sv
// tb_bus_device_port: directed-step bench for bus_device_port with id=2.
module tb_bus_device_port;
  logic clk = 0, reset = 1;
  logic tx_valid = 0, pop = 0, push = 0, rx_ready = 0;
  logic [15:0] tx_data = '0, D_push = '0;
  logic tx_ready, pndng, rx_valid, rx_overflow, rx_misroute, tx_underflow;
  logic [15:0] D_pop, rx_data;
  logic [3:0] tx_count, rx_count;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;

  bus_device_port #(.pckg_sz(16), .depth(8), .id(8'd2), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count), .rx_overflow(rx_overflow),
    .rx_misroute(rx_misroute), .tx_underflow(tx_underflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pndng"}, 32'(pndng), 0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 1);
    chk({tag, "_D_pop"}, 32'(D_pop), 0);
    chk({tag, "_rx_data"}, 32'(rx_data), 0);
    chk({tag, "_tx_count"}, 32'(tx_count), 0);
    chk({tag, "_rx_count"}, 32'(rx_count), 0);
    chk({tag, "_flags"}, {29'd0, rx_overflow, rx_misroute, tx_underflow}, 0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    chk_idle("reset");
    // single TX packet through an empty FIFO
    tx_valid = 1; tx_data = 16'h0203;
    tick();
    tx_valid = 0;
    chk("tx1_pndng", 32'(pndng), 1);
    chk("tx1_D_pop", 32'(D_pop), 32'h0203);
    chk("tx1_count", 32'(tx_count), 1);
    pop = 1;
    tick();
    pop = 0;
    chk("tx1_pop_pndng", 32'(pndng), 0);
    chk("tx1_pop_count", 32'(tx_count), 0);
    chk("tx1_underflow", 32'(tx_underflow), 0);
    // fill to full; a 9th write is refused
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1; tx_data = 16'h0100 + 16'(i);
      tick();
    end
    chk("txfull_ready", 32'(tx_ready), 0);
    chk("txfull_count", 32'(tx_count), 8);
    tx_data = 16'h0999;
    tick();
    chk("tx9_count", 32'(tx_count), 8);
    chk("tx9_head", 32'(D_pop), 32'h0100);
    // write while full with simultaneous pop: write still refused
    tx_data = 16'h0AAA; pop = 1;
    tick();
    tx_valid = 0;
    chk("txfullpop_count", 32'(tx_count), 7);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("txdrain_%0d", i), 32'(D_pop), 32'h0100 + 32'(i));
      tick();
    end
    pop = 0;
    chk("txdrain_pndng", 32'(pndng), 0);
    chk("txdrain_count", 32'(tx_count), 0);
    // underflow: pop while empty
    pop = 1;
    tick();
    pop = 0;
    chk("uf_flag", 32'(tx_underflow), 1);
    chk("uf_count", 32'(tx_count), 0);
    chk("uf_pndng", 32'(pndng), 0);
    // RX filter
    push = 1; D_push = 16'h0255; tick();
    D_push = 16'hFF11; tick();
    D_push = 16'h0377; tick();
    push = 0;
    chk("rxf_count", 32'(rx_count), 2);
    chk("rxf_misroute", 32'(rx_misroute), 1);
    chk("rxf_drop", 32'(drop_cnt), 1);
    chk("rxf_valid", 32'(rx_valid), 1);
    chk("rxf_head0", 32'(rx_data), 32'h0255);
    chk("rxf_overflow", 32'(rx_overflow), 0);
    rx_ready = 1;
    tick();
    chk("rxf_head1", 32'(rx_data), 32'hFF11);
    tick();
    rx_ready = 0;
    chk("rxf_empty_valid", 32'(rx_valid), 0);
    chk("rxf_empty_count", 32'(rx_count), 0);
    chk("rxf_empty_data", 32'(rx_data), 0);
    // RX full and overflow
    push = 1;
    for (int i = 0; i < 8; i++) begin
      D_push = 16'h0200 + 16'(i);
      tick();
    end
    chk("rxfull_count", 32'(rx_count), 8);
    D_push = 16'h0299;
    tick();
    chk("rxovf_flag", 32'(rx_overflow), 1);
    chk("rxovf_count", 32'(rx_count), 8);
    chk("rxovf_drop", 32'(drop_cnt), 2);
    D_push = 16'h02AA; rx_ready = 1;
    tick();
    chk("rxovfpop_drop", 32'(drop_cnt), 3);
    chk("rxovfpop_count", 32'(rx_count), 7);
    chk("rxovfpop_head", 32'(rx_data), 32'h0201);
    D_push = 16'h02BB;
    tick();
    push = 0;
    chk("rxsimul_count", 32'(rx_count), 7);
    chk("rxsimul_head", 32'(rx_data), 32'h0202);
    repeat (5) tick();
    rx_ready = 0;
    chk("rxpart_count", 32'(rx_count), 2);
    chk("rxpart_head", 32'(rx_data), 32'h0207);
    // drop counter saturation via misroutes
    push = 1; D_push = 16'h0511;
    repeat (255) tick();
    push = 0;
    chk("drop_sat", 32'(drop_cnt), 255);
    chk("drop_sat_rxcount", 32'(rx_count), 2);
    // TX refill after wrap, then write+pop at steady occupancy
    tx_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 16'h0300 + 16'(i);
      tick();
    end
    chk("txwrap_head", 32'(D_pop), 32'h0300);
    tx_data = 16'h0303; pop = 1;
    tick();
    tx_valid = 0; pop = 0;
    chk("txsimul_count", 32'(tx_count), 3);
    chk("txsimul_head", 32'(D_pop), 32'h0301);
    // reset mid-traffic beats concurrent writes and pushes
    reset = 1; tx_valid = 1; tx_data = 16'h0444; push = 1; D_push = 16'h0244;
    tick();
    reset = 0; tx_valid = 0; push = 0;
    chk_idle("midreset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_device_port.md
Name: bus_device_port

Overview:
- Device-side endpoint for one port of the bs_gnrtr_n_rbtr bus (generator/arbiter); the opposite end of its pndng/pop/D_pop and push/D_push handshakes.
- TX path: buffers host packets and offers them to the bus as a pending FIFO that the bus pops.
- RX path: accepts bus pushes, filters on destination ID (own ID or broadcast) and buffers accepted packets for the host.
- One instance per bus driver slot, replacing the behavioural FIFO models in the bench.

Parameters:
- pckg_sz, 16, packet width; bits [pckg_sz-1:pckg_sz-8] are the destination ID, the lower bits are payload.
- depth, 8, entries per FIFO (TX and RX); power of two, at least 2.
- id, 0, this port's 8-bit address.
- broadcast, 8'hFF, broadcast destination ID.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- tx_valid  in  1  host offers tx_data.
- tx_data  in  pckg_sz  host packet.
- tx_ready  out  1  TX FIFO not full.
- pndng  out  1  TX FIFO not empty (to bus).
- D_pop  out  pckg_sz  TX FIFO head (to bus).
- pop  in  1  bus consumes the head.
- push  in  1  bus delivers D_push.
- D_push  in  pckg_sz  delivered packet.
- rx_valid  out  1  RX FIFO not empty.
- rx_data  out  pckg_sz  RX FIFO head.
- rx_ready  in  1  host consumes the head.
- tx_count  out  $clog2(depth+1)  TX occupancy.
- rx_count  out  $clog2(depth+1)  RX occupancy.
- rx_overflow  out  1  sticky: accepted push dropped because RX was full.
- rx_misroute  out  1  sticky: push whose destination was neither id nor broadcast.
- tx_underflow  out  1  sticky: pop asserted while pndng=0.
- drop_cnt  out  8  count of RX drops (overflow plus misroute), saturates at 255.

Behaviour:
- Reset (synchronous, active-high; takes priority over every other event that cycle): both FIFOs empty, pointers 0, counts 0. Outputs: pndng=0, rx_valid=0, tx_ready=1, all sticky flags 0, drop_cnt=0. D_pop and rx_data read 0 while empty.
- TX write: occurs when tx_valid&&tx_ready at an edge. tx_ready = (tx_count!=depth), with no full-bypass: a simultaneous pop while full does not admit the write.
- TX latency: a write into an empty FIFO gives pndng=1 and D_pop=data on the following cycle.
- D_pop is first-word-fall-through and always equals the head while pndng=1.
- pop with pndng=1 advances the head. The next entry is visible the next cycle, or pndng falls to 0.
- pop with pndng=0 is ignored and sets tx_underflow.
- TX write and pop in the same cycle (not full, not empty): tx_count unchanged.
- RX filter: dest = D_push[pckg_sz-1 -: 8]. A push is accepted iff dest==id or dest==broadcast.
- Non-matching push: dropped, rx_misroute set, drop_cnt++.
- Accepted push with rx_count==depth: dropped, rx_overflow set, drop_cnt++. No bypass when full, even if rx_ready pops in the same cycle.
- Accepted push otherwise: stored. rx_valid is 1 the next cycle; rx_data is the head, FWFT.
- rx_valid&&rx_ready advances the RX head. Simultaneous store and pop keeps rx_count unchanged.
- Pointers are log2(depth) bits and wrap naturally; full/empty are derived from the counts.
- Sticky flags clear only on reset.
- drop_cnt holds at 255.

Decomposition:
- Shared package bus_pkg holds:
  - BROADCAST_ID default constant.
  - dest_of(pkt) function returning the top 8 bits.
  - typedef for count width.
- One sub-module, sync_fifo #(width, depth), instantiated twice.
  - Ports: clk, reset, wr_en, wr_data, rd_en, rd_data (FWFT), full, empty, count.
  - Writes when full and reads when empty are ignored inside sync_fifo.
- bus_device_port adds:
  - the filter;
  - the sticky flags and drop_cnt;
  - the handshake mapping.

Test Plan:
- Reset, then write 0x0203 via tx_valid -> next cycle pndng=1, D_pop=0x0203. Pulse pop -> next cycle pndng=0, tx_count=0.
- Write 8 packets 0x0100..0x0107 with no pop -> tx_ready=0 after the 8th. A 9th write is ignored. 8 pops return 0x0100..0x0107 in order, and pointers wrap on the next fill.
- id=2: push 0x0255, then 0xFF11, then 0x0377 -> rx_data yields 0x0255, then 0xFF11. rx_misroute=1, drop_cnt=1, rx_count=2.
- RX full (8 entries, rx_ready=0), push 0x0299 -> dropped, rx_overflow=1, rx_count stays 8. Next, push together with rx_ready=1 -> the push is dropped again and drop_cnt increments.
- pop asserted while pndng=0 -> tx_underflow=1, state unchanged.
- reset asserted mid-traffic, with 3 TX and 2 RX entries held -> the next cycle shows counts 0, pndng=0, rx_valid=0 and flags cleared.
